// File: rtl/free_list_if.sv
// Rename/commit-facing handshake bundle for the physical-register free list.
// The master side is rename + commit; the slave side is the free list itself.
interface free_list_if #(
  parameter int PHYS_REG_WIDTH = 6,
  parameter int COUNT_WIDTH    = 6
);
  logic                      deq_req;
  logic                      deq_valid;
  logic [PHYS_REG_WIDTH-1:0] deq_prd;
  logic                      enq_en;
  logic [PHYS_REG_WIDTH-1:0] enq_prd;
  logic                      retire_en;
  logic                      flush;
  logic [COUNT_WIDTH-1:0]    free_count;

  modport master (
    output deq_req,
    output enq_en,
    output enq_prd,
    output retire_en,
    output flush,
    input  deq_valid,
    input  deq_prd,
    input  free_count
  );

  modport slave (
    input  deq_req,
    input  enq_en,
    input  enq_prd,
    input  retire_en,
    input  flush,
    output deq_valid,
    output deq_prd,
    output free_count
  );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical register tags with R10K-style flush rewind via rhead.
// Optional same-cycle empty bypass of enqueued tags: define FREE_LIST_BYPASS_EN.
module free_list #(
  parameter int NUM_ARCH_REGS  = 32,
  parameter int NUM_PHYS_REGS  = 64,
  parameter int PHYS_REG_WIDTH = $clog2(NUM_PHYS_REGS),
  parameter int DEPTH          = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
  input  logic        clk,
  input  logic        rst,
  free_list_if.slave  fl
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]          head_reg, head_next;
  logic [PTR_W-1:0]          tail_reg, tail_next;
  logic [PTR_W-1:0]          rhead_reg, rhead_next;
  logic [PHYS_REG_WIDTH-1:0] entry_reg [DEPTH];

  logic [IDX_W-1:0]          head_idx;
  logic [IDX_W-1:0]          tail_idx;
  logic                      empty;
  logic                      full;
  logic                      enq_accept;
  logic                      bypass;
  logic                      deq_fire;

  logic [DEPTH-1:0]          entry_we;
  logic [PHYS_REG_WIDTH-1:0] entry_init [DEPTH];

  assign head_idx = head_reg[IDX_W-1:0];
  assign tail_idx = tail_reg[IDX_W-1:0];
  assign empty    = (head_reg == tail_reg);
  assign full     = (head_idx == tail_idx) && (head_reg[IDX_W] != tail_reg[IDX_W]);

  // A release into a full list can only come from a broken commit path; drop it.
  assign enq_accept = fl.enq_en && !full;

`ifdef FREE_LIST_BYPASS_EN
  // Empty implies not full, so the bypassed tag is always also written at tail.
  assign bypass = empty && fl.enq_en && !fl.flush;
`else
  assign bypass = 1'b0;
`endif

  assign fl.deq_valid  = !empty || bypass;
  assign fl.deq_prd    = bypass ? fl.enq_prd : entry_reg[head_idx];
  assign fl.free_count = tail_reg - head_reg;

  assign deq_fire = fl.deq_req && fl.deq_valid && !fl.flush;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    rhead_next = rhead_reg;

    if (fl.flush) begin
      head_next = rhead_reg + PTR_W'(fl.retire_en);
    end else if (deq_fire) begin
      head_next = head_reg + PTR_W'(1);
    end

    if (enq_accept) begin
      tail_next = tail_reg + PTR_W'(1);
    end

    if (fl.retire_en) begin
      rhead_next = rhead_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      rhead_reg <= '0;
      tail_reg  <= PTR_W'(DEPTH);
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      rhead_reg <= rhead_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_we[gi]   = enq_accept && (tail_idx == IDX_W'(gi));
      assign entry_init[gi] = PHYS_REG_WIDTH'(NUM_ARCH_REGS + gi);
    end
  endgenerate

  // After reset every non-architectural tag sits in the list in ascending order.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        entry_reg[i] <= entry_init[i];
      end else if (entry_we[i]) begin
        entry_reg[i] <= fl.enq_prd;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fl.enq_en && full))
        else $warning("free_list: release of tag %0d into a full list dropped", fl.enq_prd);
      assert (!(fl.retire_en && (rhead_reg == head_reg) && !deq_fire))
        else $error("free_list: retire head overtook allocation head");
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: drain, refill, flush rewind, full-list release, mixed traffic.
module tb_free_list;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  free_list_if #(.PHYS_REG_WIDTH(6), .COUNT_WIDTH(6)) fl_if ();

  free_list dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fl_if.deq_req   = 1'b0;
    fl_if.enq_en    = 1'b0;
    fl_if.enq_prd   = '0;
    fl_if.retire_en = 1'b0;
    fl_if.flush     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Dequeue n tags back to back with no checking.
  task automatic deq_n(input int n);
    for (int i = 0; i < n; i++) begin
      fl_if.deq_req = 1'b1;
      tick();
    end
    fl_if.deq_req = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (fl_if.deq_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_valid: got %0b expected 1", fl_if.deq_valid);
    end
    checks++;
    if (fl_if.deq_prd !== 6'd32) begin
      errors++;
      $display("FAIL reset_prd: got %0d expected 32", fl_if.deq_prd);
    end
    checks++;
    if (fl_if.free_count !== 6'd32) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 32", fl_if.free_count);
    end
    $display("test_reset: valid=%0b prd=%0d count=%0d", fl_if.deq_valid, fl_if.deq_prd, fl_if.free_count);
  endtask

  task automatic test_drain();
    logic [5:0] exp_prd;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      fl_if.deq_req = 1'b1;
      exp_prd = 6'(32 + i);
      #1;
      checks++;
      if (fl_if.deq_valid !== 1'b1 || fl_if.deq_prd !== exp_prd) begin
        errors++;
        $display("FAIL drain_prd[%0d]: got valid=%0b prd=%0d expected valid=1 prd=%0d",
                 i, fl_if.deq_valid, fl_if.deq_prd, exp_prd);
      end
      $display("deq %0d: tag=%0d", i, fl_if.deq_prd);
      tick();
    end
    fl_if.deq_req = 1'b0;
    #1;
    checks++;
    if (fl_if.deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty_valid: got %0b expected 0", fl_if.deq_valid);
    end
    checks++;
    if (fl_if.free_count !== 6'd0) begin
      errors++;
      $display("FAIL drain_empty_count: got %0d expected 0", fl_if.free_count);
    end
    // Dequeue request while empty must not move anything.
    fl_if.deq_req = 1'b1;
    tick();
    fl_if.deq_req = 1'b0;
    #1;
    checks++;
    if (fl_if.free_count !== 6'd0) begin
      errors++;
      $display("FAIL empty_deq_noop: got count=%0d expected 0", fl_if.free_count);
    end
  endtask

  task automatic test_enqueue();
    // Continues from the empty list left by test_drain.
    fl_if.enq_en  = 1'b1;
    fl_if.enq_prd = 6'd5;
    #1;
`ifdef FREE_LIST_BYPASS_EN
    checks++;
    if (fl_if.deq_valid !== 1'b1 || fl_if.deq_prd !== 6'd5) begin
      errors++;
      $display("FAIL bypass_same_cycle: got valid=%0b prd=%0d expected valid=1 prd=5",
               fl_if.deq_valid, fl_if.deq_prd);
    end
`else
    checks++;
    if (fl_if.deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL enq_same_cycle_valid: got %0b expected 0", fl_if.deq_valid);
    end
`endif
    tick();
    idle_inputs();
    #1;
    checks++;
    if (fl_if.deq_valid !== 1'b1 || fl_if.deq_prd !== 6'd5 || fl_if.free_count !== 6'd1) begin
      errors++;
      $display("FAIL enq_next_cycle: got valid=%0b prd=%0d count=%0d expected valid=1 prd=5 count=1",
               fl_if.deq_valid, fl_if.deq_prd, fl_if.free_count);
    end
    $display("enq tag=5: count=%0d", fl_if.free_count);
  endtask

  task automatic test_empty_enq_deq();
    do_reset();
    deq_n(32);
    fl_if.enq_en  = 1'b1;
    fl_if.enq_prd = 6'd12;
    fl_if.deq_req = 1'b1;
    tick();
    idle_inputs();
    #1;
`ifdef FREE_LIST_BYPASS_EN
    checks++;
    if (fl_if.free_count !== 6'd0 || fl_if.deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL bypass_consume: got count=%0d valid=%0b expected count=0 valid=0",
               fl_if.free_count, fl_if.deq_valid);
    end
`else
    checks++;
    if (fl_if.free_count !== 6'd1 || fl_if.deq_prd !== 6'd12) begin
      errors++;
      $display("FAIL empty_enq_deq: got count=%0d prd=%0d expected count=1 prd=12",
               fl_if.free_count, fl_if.deq_prd);
    end
`endif
    $display("enq+deq from empty tag=12: count=%0d", fl_if.free_count);
  endtask

  task automatic test_flush();
    do_reset();
    deq_n(4);
    fl_if.retire_en = 1'b1;
    tick();
    tick();
    fl_if.retire_en = 1'b0;
    #1;
    checks++;
    if (fl_if.free_count !== 6'd28) begin
      errors++;
      $display("FAIL pre_flush_count: got %0d expected 28", fl_if.free_count);
    end
    fl_if.flush = 1'b1;
    tick();
    fl_if.flush = 1'b0;
    #1;
    checks++;
    if (fl_if.deq_prd !== 6'd34 || fl_if.free_count !== 6'd30) begin
      errors++;
      $display("FAIL flush_rewind: got prd=%0d count=%0d expected prd=34 count=30",
               fl_if.deq_prd, fl_if.free_count);
    end
    $display("flush: prd=%0d count=%0d", fl_if.deq_prd, fl_if.free_count);
  endtask

  task automatic test_flush_deq_retire();
    do_reset();
    deq_n(4);
    fl_if.retire_en = 1'b1;
    tick();
    // Flush with a competing dequeue, a retire and a release in the same cycle.
    fl_if.flush     = 1'b1;
    fl_if.deq_req   = 1'b1;
    fl_if.retire_en = 1'b1;
    fl_if.enq_en    = 1'b1;
    fl_if.enq_prd   = 6'd40;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (fl_if.deq_prd !== 6'd34) begin
      errors++;
      $display("FAIL flush_deq_retire_prd: got %0d expected 34", fl_if.deq_prd);
    end
    checks++;
    if (fl_if.free_count !== 6'd31) begin
      errors++;
      $display("FAIL flush_deq_retire_count: got %0d expected 31", fl_if.free_count);
    end
    $display("flush+deq+retire+enq: prd=%0d count=%0d", fl_if.deq_prd, fl_if.free_count);
  endtask

  task automatic test_enq_full();
    do_reset();
    fl_if.enq_en  = 1'b1;
    fl_if.enq_prd = 6'd9;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (fl_if.free_count !== 6'd32 || fl_if.deq_prd !== 6'd32) begin
      errors++;
      $display("FAIL enq_full_ignored: got count=%0d prd=%0d expected count=32 prd=32",
               fl_if.free_count, fl_if.deq_prd);
    end
    $display("enq into full list tag=9: count=%0d", fl_if.free_count);
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_seq [10];
    do_reset();
    deq_n(22);
    checks++;
    if (fl_if.free_count !== 6'd10) begin
      errors++;
      $display("FAIL b2b_setup_count: got %0d expected 10", fl_if.free_count);
    end
    fl_if.enq_en  = 1'b1;
    fl_if.enq_prd = 6'd7;
    fl_if.deq_req = 1'b1;
    #1;
    checks++;
    if (fl_if.deq_prd !== 6'd54) begin
      errors++;
      $display("FAIL b2b_first_prd: got %0d expected 54", fl_if.deq_prd);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (fl_if.free_count !== 6'd10) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 10", fl_if.free_count);
    end
    for (int i = 0; i < 9; i++) exp_seq[i] = 6'(55 + i);
    exp_seq[9] = 6'd7;
    for (int i = 0; i < 10; i++) begin
      fl_if.deq_req = 1'b1;
      #1;
      checks++;
      if (fl_if.deq_valid !== 1'b1 || fl_if.deq_prd !== exp_seq[i]) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got valid=%0b prd=%0d expected valid=1 prd=%0d",
                 i, fl_if.deq_valid, fl_if.deq_prd, exp_seq[i]);
      end
      $display("deq after mixed traffic %0d: tag=%0d", i, fl_if.deq_prd);
      tick();
    end
    fl_if.deq_req = 1'b0;
    #1;
    checks++;
    if (fl_if.free_count !== 6'd0 || fl_if.deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final_empty: got count=%0d valid=%0b expected count=0 valid=0",
               fl_if.free_count, fl_if.deq_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    deq_n(7);
    fl_if.deq_req = 1'b1;
    fl_if.enq_en  = 1'b1;
    fl_if.enq_prd = 6'd3;
    fl_if.flush   = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (fl_if.free_count !== 6'd32 || fl_if.deq_prd !== 6'd32 || fl_if.deq_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got count=%0d prd=%0d valid=%0b expected count=32 prd=32 valid=1",
               fl_if.free_count, fl_if.deq_prd, fl_if.deq_valid);
    end
    $display("reset mid-operation: count=%0d prd=%0d", fl_if.free_count, fl_if.deq_prd);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_drain();
    test_enqueue();
    test_empty_enq_deq();
    test_flush();
    test_flush_deq_retire();
    test_enq_full();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
